// File: rtl/jtopl_pkg.sv
// Shared OPL definitions: slot-to-channel map, rhythm drum bit positions and
// the CSM sequencer state encoding.
package jtopl_pkg;

  localparam int DRUM_HH  = 0;
  localparam int DRUM_TC  = 1;
  localparam int DRUM_TOM = 2;
  localparam int DRUM_SD  = 3;
  localparam int DRUM_BD  = 4;

  typedef enum logic [1:0] {
    CSM_IDLE = 2'd0,
    CSM_PEND = 2'd1,
    CSM_ON   = 2'd2
  } csm_state_e;

  // s = 6g + 3op + k  ->  channel = 3g + k
  function automatic logic [3:0] slot_ch(input logic [4:0] s);
    logic [3:0] ch;
    case (s)
      5'd0,  5'd3:  ch = 4'd0;
      5'd1,  5'd4:  ch = 4'd1;
      5'd2,  5'd5:  ch = 4'd2;
      5'd6,  5'd9:  ch = 4'd3;
      5'd7,  5'd10: ch = 4'd4;
      5'd8,  5'd11: ch = 4'd5;
      5'd12, 5'd15: ch = 4'd6;
      5'd13, 5'd16: ch = 4'd7;
      5'd14, 5'd17: ch = 4'd8;
      default:      ch = 4'd0;
    endcase
    return ch;
  endfunction

  // Rhythm-mode drum bit that drives a given slot (0 for melodic-only slots)
  function automatic logic slot_drum(input logic [4:0] s, input logic [4:0] rhy);
    logic d;
    case (s)
      5'd12, 5'd15: d = rhy[DRUM_BD];
      5'd13:        d = rhy[DRUM_HH];
      5'd14:        d = rhy[DRUM_TOM];
      5'd16:        d = rhy[DRUM_SD];
      5'd17:        d = rhy[DRUM_TC];
      default:      d = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/jtopl_kon_csm.sv
// CSM key-on sequencer: a timer A trigger keys every slot on for exactly the
// round that follows the next round boundary.
module jtopl_kon_csm
  import jtopl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic cenop,
  input  logic zero,
  input  logic csm_en,
  input  logic csm_trig,
  output logic csm_on_nxt,
  output logic csm_busy,
  output logic csm_miss
);

  csm_state_e state_q, state_d;
  logic       miss_q, miss_d;

  always_comb begin
    state_d = state_q;
    miss_d  = miss_q;
    if (cenop) begin
      miss_d = 1'b0;
      if (!csm_en) begin
        state_d = CSM_IDLE;
      end else begin
        case (state_q)
          CSM_IDLE: if (csm_trig) state_d = CSM_PEND;
          CSM_PEND: begin
            if (zero) state_d = CSM_ON;
            miss_d = csm_trig;
          end
          CSM_ON: begin
            if (zero) state_d = CSM_IDLE;
            miss_d = csm_trig;
          end
          default: state_d = CSM_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CSM_IDLE;
      miss_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      miss_q  <= miss_d;
    end
  end

  // The top computes keyon_I from the post-transition state
  assign csm_on_nxt = (state_d == CSM_ON);
  assign csm_busy   = (state_q != CSM_IDLE);
  assign csm_miss   = miss_q;

endmodule

// File: rtl/jtopl_kon_sched.sv
// Key-on scheduler: commits CPU, rhythm and CSM key requests at the round
// boundary and serialises them into per-slot keyon_I for the EG.
module jtopl_kon_sched
  import jtopl_pkg::*;
#(
  parameter int SLOTS = 18,
  parameter int CH    = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cenop,
  input  logic       zero,
  input  logic       kon_we,
  input  logic [3:0] kon_ch,
  input  logic       kon_din,
  input  logic       rhy_en,
  input  logic [4:0] rhy_kon,
  input  logic       csm_en,
  input  logic       csm_trig,
  output logic       keyon_I,
  output logic [4:0] slot_cnt,
  output logic       csm_busy,
  output logic       csm_miss
);

  logic [CH-1:0] pend_q, pend_d;
  logic [CH-1:0] kon_q,  kon_d;
  logic [4:0]    rhy_q,  rhy_d;
  logic [4:0]    slot_q, slot_d;
  logic          keyon_q, keyon_d;
  logic          csm_on_nxt;

  jtopl_kon_csm u_csm (
    .clk        (clk),
    .rst        (rst),
    .cenop      (cenop),
    .zero       (zero),
    .csm_en     (csm_en),
    .csm_trig   (csm_trig),
    .csm_on_nxt (csm_on_nxt),
    .csm_busy   (csm_busy),
    .csm_miss   (csm_miss)
  );

  always_comb begin
    pend_d  = pend_q;
    kon_d   = kon_q;
    rhy_d   = rhy_q;
    slot_d  = slot_q;
    keyon_d = keyon_q;
    if (cenop) begin
      if (kon_we && (kon_ch < 4'(CH))) pend_d[kon_ch] = kon_din;
      if (zero) begin
        // A write landing on the boundary cycle joins this commit
        slot_d = 5'd0;
        kon_d  = pend_d;
        rhy_d  = rhy_kon;
      end else if (slot_q == 5'(SLOTS - 1)) begin
        slot_d = 5'd0;
      end else begin
        slot_d = slot_q + 5'd1;
      end
      keyon_d = kon_d[slot_ch(slot_d)]
              | (rhy_en & slot_drum(slot_d, rhy_d))
              | csm_on_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q  <= '0;
      kon_q   <= '0;
      rhy_q   <= '0;
      slot_q  <= '0;
      keyon_q <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      kon_q   <= kon_d;
      rhy_q   <= rhy_d;
      slot_q  <= slot_d;
      keyon_q <= keyon_d;
    end
  end

  assign keyon_I  = keyon_q;
  assign slot_cnt = slot_q;

endmodule

// File: doc/jtopl_kon_sched.md
# jtopl_kon_sched

Key-on scheduler for the OPL envelope generator. It gathers key-on requests from three sources and serialises them into the per-slot `keyon_I` bit that the EG consumes in slot order: CPU writes to the channel key-on bits, rhythm-mode drum bits, and CSM (timer A overflow) triggers. All requests commit at the round boundary, so both operators of a channel always see the same key edge within one round. It sits between the register file/timers and `jtopl_eg`, and runs on the same `cenop`/`zero` timebase.

## Interface
Parameters:
- `SLOTS`, 18, operator slots per round (fixed slot/channel map below assumes 18)
- `CH`, 9, melodic channels

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `cenop`  in  1  slot clock enable; all state advances only when high
- `zero`  in  1  high on the `cenop` cycle that closes a round (EG stage I at slot 17)
- `kon_we`  in  1  CPU write strobe to a channel key-on bit (qualified by `cenop`)
- `kon_ch`  in  4  channel 0..8 for `kon_we`; values 9..15 are ignored
- `kon_din`  in  1  key-on value written
- `rhy_en`  in  1  rhythm mode enable
- `rhy_kon`  in  5  drum bits {BD,SD,TOM,TC,HH} = [4:0]
- `csm_en`  in  1  CSM mode enable
- `csm_trig`  in  1  timer A overflow pulse (qualified by `cenop`)
- `keyon_I`  out  1  key-on for the slot in `slot_cnt`, feeds EG stage I
- `slot_cnt`  out  5  slot index that `keyon_I` belongs to
- `csm_busy`  out  1  CSM sequence pending or active
- `csm_miss`  out  1  one-`cenop` pulse: a trigger was dropped

## Operation
- Slot map: s = 6g + 3op + k, with g in 0..2, op in 0..1, k in 0..2; channel = 3g + k.
- Registers: `pend[8:0]` is written immediately by `kon_we`. `kon[8:0]` and `rhy_q[4:0]` are committed from `pend`/`rhy_kon` on each `zero` edge.
  - A write on the `zero` cycle is included in that same commit.
- Rhythm, when `rhy_en` is high, ORs onto the committed channel bits:
  - BD → slots 12, 15
  - HH → 13
  - SD → 16
  - TOM → 14
  - TC → 17
- CSM FSM:
  - IDLE → PEND on `csm_trig & csm_en`.
  - PEND → ON at `zero`.
  - ON → IDLE at the next `zero`.
  - A trigger in PEND or ON is dropped and pulses `csm_miss`.
  - Clearing `csm_en` forces IDLE on the next `cenop`.
  - While ON, every slot's key-on is forced to 1.
- Slot value = `kon[ch]` | (`rhy_en` & drum bit for slot) | (csm state is ON).
- `csm_busy` = state is not IDLE.

## Timing
- Reset values: `keyon_I` = 0, `slot_cnt` = 0, `csm_miss` = 0, `csm_busy` = 0, `pend` = `kon` = `rhy_q` = 0, CSM state IDLE.
- With `cenop` low, everything holds.
- On a `cenop` edge:
  - If `zero` is high: `slot_cnt` ← 0, commit happens, and the CSM transition happens. `keyon_I` ← slot 0 value, computed from the post-commit, post-transition state.
  - Otherwise: `slot_cnt` ← `slot_cnt` + 1, wrapping 17 → 0 even without `zero`. `keyon_I` ← the value for the new index.
- Latency: a write becomes visible on slot 0 of the round after the next `zero`. The exception is a write on the `zero` cycle itself, which is visible on slot 0 immediately.
- CSM timing: a trigger makes keys 1 for exactly the 18 slots of the next round. The following round returns to the register values, which gives the EG its key-off edge.
- A trigger coincident with `zero` while IDLE: enters PEND and waits for the next `zero`.
- Reset mid-round: all outputs return to reset values on the next `clk`, regardless of `cenop`.

## Structure
- Shared package `jtopl_pkg`: slot→channel function, drum bit indices, CSM state encoding (IDLE=0, PEND=1, ON=2).
- One sub-module, `jtopl_kon_csm`: the CSM FSM with `csm_busy`/`csm_miss` outputs.
- Everything else lives in the top module (slot counter, commit registers, output mux).

## Test plan
- Reset, then 36 `cenop` cycles with `zero` every 18 → `keyon_I` = 0 throughout, and `slot_cnt` runs 0..17 twice.
- `kon_we` with ch0, din=1 at slot 5 → `keyon_I` = 1 only at slots 0 and 3, starting from the round after the next `zero`. `kon_we` with ch4 on the `zero` cycle → slots 7 and 10 high in the immediately following round.
- `rhy_en`=1, `rhy_kon`=5'b10001 (BD, HH) → slots 12, 13, 15 high. `rhy_en`=0 → those slots low.
- `csm_en`=1, `csm_trig` at slot 3 → `csm_busy`=1. The next round has all 18 slots at 1; the round after returns to register values; `csm_busy` falls at the second `zero`.
- Second `csm_trig` while ON → `csm_miss` pulses for exactly one `cenop`, and the ON round is not extended.
- `rst` at slot 9 while ch2 is keyed and CSM is ON → next cycle all outputs are 0 and the state is IDLE; the ch2 key stays off after reset.
